irq_ctrl: RTL and testbench
===========================

// Module: irq_ctrl
// PURPOSE
//  Interrupt controller between the timer/peripheral IRQ lines and the CPU's CP0 HWInt input.
//  Latches edge/level requests and applies a per-source mask.
//  Selects the highest-priority source and runs a claim / end-of-interrupt (EOI) handshake.
//  Word-addressed bus slave on the bridge, with the same Addr/Wd/We/Rd style as the timers.
// PARAMETERS
//  N_SRC  6  number of interrupt sources (1..8); source 0 = highest priority
// PORTS
//  Clk    in   1      system clock, all state on posedge
//  Reset  in   1      asynchronous, active-low reset (0 = reset)
//  IrqIn  in   N_SRC  raw request lines from timers/devices, Clk-synchronous
//  Addr   in   2      register select: 0 MASK, 1 PEND, 2 MODE, 3 CLAIM
//  Wd     in   32     write data
//  We     in   1      write strobe, one cycle
//  Re     in   1      read strobe; side effect only at Addr 3
//  Rd     out  32     read data, combinational from Addr
//  IRQ    out  1      interrupt request to CP0
//  InSvc  out  1      1 while a claimed interrupt awaits EOI
// BEHAVIOUR
//  Reset (async, Reset=0):
//   - mask, pend, mode, irq_q and cur_id are all 0; state = IDLE; IRQ = 0; InSvc = 0.
//  Registers (unused high bits read as 0):
//   - MASK: RW, bits [N_SRC-1:0].
//   - MODE: RW; bit i = 1 makes source i edge-triggered, 0 makes it level-triggered.
//   - PEND: R; a write of 1 (W1C) clears an edge-mode bit only.
//   - CLAIM read: {valid[31], InSvc[30], 27'b0, id[2:0]}. id = lowest index in act; valid = |act.
//  Input tracking:
//   - irq_q <= IrqIn every cycle.
//   - Edge source: pend set on IrqIn & ~irq_q. Set wins over W1C or claim-clear in the same cycle.
//   - Level source: pend <= IrqIn every cycle; W1C is ignored.
//  Selection: act = pend & mask.
//  FSM (registered):
//   - IDLE: |act -> REQ.
//   - REQ: IRQ = 1.
//     - act == 0 (masked or cleared) -> IDLE, no claim.
//     - Re & Addr==3 -> SERVICE: cur_id <= returned id; clear pend[id] if edge mode.
//   - SERVICE: IRQ = 0, InSvc = 1; no new claims are taken (valid still reads live act).
//     - We & Addr==3 & Wd[2:0]==cur_id -> IDLE.
//     - EOI with a mismatched id is ignored; state stays SERVICE.
//   - A claim read in IDLE or SERVICE returns the current value and has no side effect.
//   - EOI while in IDLE or REQ is ignored.
//  Latency:
//   - IrqIn sampled high at edge E0 -> pend=1 after E0 -> IRQ=1 after E1 (2 cycles).
//   - The EOI edge returns to IDLE; a still-active source re-raises IRQ one cycle later.
//  Priority: fixed and non-preemptive; a higher source arriving during SERVICE waits for EOI.
//  Simultaneous events:
//   - We and Re on the same cycle: the write applies and the claim is still taken.
//   - A mask write in the same cycle as a claim: the claim uses the pre-write act.
//  Reset asserted mid-SERVICE: all state clears immediately; IRQ drops asynchronously.
// TESTING
//  1. Reset=0, then release -> Rd at all Addr = 0, IRQ = 0, InSvc = 0.
//  2. MODE=0x01, MASK=0x01; 1-cycle IrqIn[0] pulse
//     -> IRQ = 1 two edges later.
//     -> claim reads 0x80000000; PEND = 0; InSvc = 1.
//     -> EOI Wd=0 -> IRQ stays 0.
//  3. MASK=0x06; IrqIn[1] and IrqIn[2] held high, level mode
//     -> claim returns id 1.
//     -> EOI id 1 -> IRQ re-asserts; next claim returns id 1 again while the level is still high.
//  4. In SERVICE with cur_id=2, EOI Wd=3 -> state unchanged, InSvc = 1; EOI Wd=2 -> InSvc = 0.
//  5. Edge pending on source 0 and IrqIn[0] rising in the same cycle as a PEND W1C of 0x1
//     -> PEND bit 0 reads 1.
//  6. Reset=0 pulse during SERVICE -> IRQ = 0, InSvc = 0, PEND = 0 with no clock edge.
//     Then release; a fresh edge -> IRQ after 2 edges.

Source files
------------

// File: rtl/irq_ctrl.sv
// irq_ctrl: masked edge/level interrupt controller with fixed priority and claim/EOI handshake
module irq_ctrl #(
  parameter int N_SRC = 6
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic [N_SRC-1:0] IrqIn,
  input  logic [1:0]       Addr,
  input  logic [31:0]      Wd,
  input  logic             We,
  input  logic             Re,
  output logic [31:0]      Rd,
  output logic             IRQ,
  output logic             InSvc
);
  typedef enum logic [1:0] {IDLE, REQ, SERVICE} state_t;
  state_t state_q, state_d;
  logic [N_SRC-1:0] mask_q, mask_d, pend_q, pend_d, mode_q, mode_d, irq_q, act;
  logic [2:0] cur_id_q, cur_id_d, id;
  logic valid, claim, eoi;
  assign act = pend_q & mask_q;
  assign valid = |act;
  assign IRQ = state_q == REQ;
  assign InSvc = state_q == SERVICE;
  assign claim = state_q == REQ && valid && Re && Addr == 2'd3;
  assign eoi = state_q == SERVICE && We && Addr == 2'd3 && Wd[2:0] == cur_id_q;
  assign Rd = Addr == 2'd0 ? 32'(mask_q) :
              Addr == 2'd1 ? 32'(pend_q) :
              Addr == 2'd2 ? 32'(mode_q) :
              {valid, InSvc, 27'b0, id};
  always_comb begin
    id = '0;
    for (int i = N_SRC - 1; i >= 0; i--) if (act[i]) id = 3'(i);
    mask_d = We && Addr == 2'd0 ? Wd[N_SRC-1:0] : mask_q;
    mode_d = We && Addr == 2'd2 ? Wd[N_SRC-1:0] : mode_q;
    pend_d = pend_q;
    // a new edge outranks both W1C and the claim clear
    for (int i = 0; i < N_SRC; i++)
      pend_d[i] = mode_q[i] ? (IrqIn[i] & ~irq_q[i]) |
                              (pend_q[i] & ~((We && Addr == 2'd1 && Wd[i]) || (claim && id == 3'(i))))
                            : IrqIn[i];
    state_d = state_q == IDLE ? (valid ? REQ : IDLE) :
              state_q == REQ  ? (!valid ? IDLE : claim ? SERVICE : REQ) :
              eoi ? IDLE : SERVICE;
    cur_id_d = claim ? id : cur_id_q;
  end
  always_ff @(posedge Clk or negedge Reset)
    if (!Reset) begin
      state_q <= IDLE;
      mask_q <= '0;
      pend_q <= '0;
      mode_q <= '0;
      irq_q <= '0;
      cur_id_q <= '0;
    end else begin
      state_q <= state_d;
      mask_q <= mask_d;
      pend_q <= pend_d;
      mode_q <= mode_d;
      irq_q <= IrqIn;
      cur_id_q <= cur_id_d;
    end
endmodule

// File: tb/tb_irq_ctrl.sv
// tb_irq_ctrl: directed scoreboard bench for irq_ctrl; stimulus queues expectations, a negedge monitor checks them
module tb_irq_ctrl;
  logic Clk = 0, Reset = 0, We = 0, Re = 0, IRQ, InSvc;
  logic [5:0] IrqIn = '0;
  logic [1:0] Addr = '0;
  logic [31:0] Wd = '0, Rd;
  int n_cmp = 0, n_bad = 0;
  typedef struct {string name; int kind; logic [31:0] exp;} exp_t;
  exp_t q[$];

  irq_ctrl #(.N_SRC(6)) dut (.Clk(Clk), .Reset(Reset), .IrqIn(IrqIn), .Addr(Addr), .Wd(Wd),
    .We(We), .Re(Re), .Rd(Rd), .IRQ(IRQ), .InSvc(InSvc));

  always #5 Clk = ~Clk;

  // kind 0 = Rd, 1 = IRQ, 2 = InSvc; expectations queued in a cycle are checked at its negedge
  always @(negedge Clk) begin
    logic [31:0] act;
    while (q.size() != 0) begin
      exp_t e;
      e = q.pop_front();
      act = e.kind == 0 ? Rd : e.kind == 1 ? 32'(IRQ) : 32'(InSvc);
      n_cmp++;
      if (act !== e.exp) begin
        n_bad++;
        $display("FAIL %s: got 0x%08h want 0x%08h", e.name, act, e.exp);
      end
    end
  end

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask
  task automatic push(input string name, input int kind, input logic [31:0] exp);
    exp_t e;
    e.name = name; e.kind = kind; e.exp = exp;
    q.push_back(e);
  endtask
  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    Addr = a; Wd = d; We = 1;
    tick();
    We = 0;
  endtask
  task automatic rd(input string name, input logic [1:0] a, input logic [31:0] exp);
    Addr = a;
    push(name, 0, exp);
    tick();
  endtask
  task automatic claim(input string name, input logic [31:0] exp);
    Addr = 2'd3; Re = 1;
    push(name, 0, exp);
    tick();
    Re = 0;
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin
    repeat (2) tick();
    Reset = 1;
    // 1: reset state
    push("rst_irq", 1, 0); push("rst_insvc", 2, 0);
    rd("rst_mask", 0, 0); rd("rst_pend", 1, 0); rd("rst_mode", 2, 0); rd("rst_claim", 3, 0);
    // 2: edge source 0, single-cycle pulse
    wr(2, 1); wr(0, 1);
    IrqIn = 6'h01; tick();
    IrqIn = 0; push("t2_irq_e0", 1, 0); tick();
    push("t2_irq_e1", 1, 1); claim("t2_claim", 32'h8000_0000);
    push("t2_insvc", 2, 1); push("t2_irq_svc", 1, 0); rd("t2_pend", 1, 0);
    wr(3, 0);
    push("t2_eoi_irq", 1, 0); push("t2_eoi_insvc", 2, 0); tick();
    push("t2_irq_quiet", 1, 0); tick();
    // 3: level sources 1 and 2, priority and re-raise after EOI
    wr(2, 0); wr(0, 6);
    IrqIn = 6'h06; tick(); tick();
    push("t3_irq", 1, 1); claim("t3_claim1", 32'h8000_0001);
    push("t3_insvc", 2, 1); wr(3, 1);
    push("t3_irq_idle", 1, 0); tick();
    push("t3_irq_again", 1, 1); claim("t3_claim2", 32'h8000_0001);
    wr(3, 1); wr(0, 4);
    push("t3_irq_src2", 1, 1); claim("t3_claim3", 32'h8000_0002);
    // 4: mismatched EOI ignored, matching EOI ends service
    wr(3, 3);
    push("t4_insvc_bad", 2, 1); push("t4_irq_bad", 1, 0); rd("t4_claim_svc", 3, 32'hC000_0002);
    wr(3, 2);
    push("t4_insvc_eoi", 2, 0); tick();
    IrqIn = 0; wr(0, 0); tick();
    push("t4_irq_quiet", 1, 0); tick();
    // 5: rising edge beats same-cycle W1C; W1C alone clears; level ignores W1C
    wr(2, 1);
    IrqIn = 6'h01; tick();
    IrqIn = 0; tick();
    IrqIn = 6'h01; wr(1, 1);
    rd("t5_pend_setwins", 1, 1);
    wr(1, 1); rd("t5_pend_w1c", 1, 0);
    wr(2, 0); tick(); wr(1, 1);
    rd("t5_pend_level", 1, 1);
    IrqIn = 0; tick(); tick();
    // 6: asynchronous reset in SERVICE, then fresh edge
    wr(2, 1); wr(0, 1);
    IrqIn = 6'h01; tick();
    IrqIn = 0; tick();
    claim("t6_claim", 32'h8000_0000);
    IrqIn = 6'h01; tick();
    IrqIn = 0; tick();
    push("t6_insvc", 2, 1); rd("t6_pend_svc", 1, 1);
    Reset = 0; #1;
    Addr = 2'd1;
    push("t6_rst_irq", 1, 0); push("t6_rst_insvc", 2, 0); push("t6_rst_pend", 0, 0);
    tick();
    Reset = 1;
    wr(2, 1); wr(0, 1);
    IrqIn = 6'h01; tick();
    IrqIn = 0; push("t6_irq_e0", 1, 0); tick();
    push("t6_irq_e1", 1, 1); tick();
    repeat (3) tick();
    n_cmp++;
    if (q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: got %0d pending want 0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
